// File: rtl/pe_pkg.sv
// Shared widths, constants and saturating arithmetic for the convolution PE MAC.
// The default-configuration constants mirror the top-level parameter defaults.
package pe_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_TAPS   = 9;
  localparam int DEF_ACC_W  = 32;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  localparam int PROD_W = DEF_DATA_W + DEF_COEF_W;
  localparam int TREE_W = PROD_W + clog2(DEF_TAPS);

  localparam logic signed [63:0] ACC_MAX = (64'sd1 <<< (DEF_ACC_W - 1)) - 64'sd1;
  localparam logic signed [63:0] ACC_MIN = -(64'sd1 <<< (DEF_ACC_W - 1));

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_res_t;

  function automatic logic signed [63:0] acc_max(input int w);
    if (w == DEF_ACC_W) begin
      return ACC_MAX;
    end else begin
      return (64'sd1 <<< (w - 1)) - 64'sd1;
    end
  endfunction

  function automatic logic signed [63:0] acc_min(input int w);
    if (w == DEF_ACC_W) begin
      return ACC_MIN;
    end else begin
      return -(64'sd1 <<< (w - 1));
    end
  endfunction

  // Signed add of two sign-extended operands, clamped to a w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_res_t           r;
    hi = 65'(acc_max(w));
    lo = 65'(acc_min(w));
    s  = 65'(a) + 65'(b);
    if (s > hi) begin
      r.ovf = 1'b1;
      r.val = acc_max(w);
    end else if (s < lo) begin
      r.ovf = 1'b1;
      r.val = acc_min(w);
    end else begin
      r.ovf = 1'b0;
      r.val = s[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Registered pairwise reduction of N signed products into one OUT_W sum.
// The tree is combinational; a single register level sits at its root.
module pe_adder_tree
  import pe_pkg::*;
#(
  parameter int N     = DEF_TAPS,
  parameter int IN_W  = PROD_W,
  parameter int OUT_W = TREE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic [N*IN_W-1:0]       i_data,
  output logic                    o_valid,
  output logic                    o_first,
  output logic                    o_last,
  output logic signed [OUT_W-1:0] o_sum
);

  localparam int LV = clog2(N);
  localparam int NP = 1 << LV;

  // Level 0 holds the sign-extended leaves padded with zeros up to a power of two.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic signed [OUT_W-1:0] w_node [NP >> l];
    for (genvar j = 0; j < (NP >> l); j++) begin : g_node
      if (l == 0) begin : g_leaf
        if (j < N) begin : g_in
          assign w_node[j] = OUT_W'($signed(i_data[j*IN_W +: IN_W]));
        end else begin : g_pad
          assign w_node[j] = '0;
        end
      end else begin : g_add
        assign w_node[j] = g_lvl[l-1].w_node[2*j] + g_lvl[l-1].w_node[2*j+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      o_sum   <= '0;
    end else begin
      o_valid <= i_valid;
      o_first <= i_first;
      o_last  <= i_last;
      if (i_valid) begin
        o_sum <= g_lvl[LV].w_node[0];
      end
    end
  end

endmodule

// File: rtl/conv_pe_mac.sv
// Convolution PE: serially loaded kernel, window multiply, registered adder tree,
// saturating channel accumulator. Define PE_RELU_EN to clamp emitted results at zero.
module conv_pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     kernel_load_valid,
  input  logic [COEF_W-1:0]        kernel_data,
  output logic                     kernel_loaded,
  input  logic                     win_valid,
  output logic                     win_ready,
  input  logic                     win_first,
  input  logic                     win_last,
  input  logic [TAPS*DATA_W-1:0]   win_data,
  output logic                     acc_valid,
  output logic [ACC_W-1:0]         acc_data,
  output logic                     acc_sat
);

  localparam int P_W   = DATA_W + COEF_W;
  localparam int IDX_W = (TAPS > 1) ? clog2(TAPS) : 1;

  logic signed [COEF_W-1:0] r_kernel [TAPS];
  logic [IDX_W-1:0]         r_kidx;
  logic                     r_loaded;
  logic                     w_accept;

  logic [TAPS*P_W-1:0]      r_prod;
  logic                     r_s1_valid;
  logic                     r_s1_first;
  logic                     r_s1_last;

  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_s2_valid;
  logic                     w_s2_first;
  logic                     w_s2_last;

  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_sat;
  logic signed [ACC_W-1:0]  w_base;
  logic                     w_sat_base;
  sat_res_t                 w_add;
  logic signed [ACC_W-1:0]  w_res;
  logic                     w_sat_new;
  logic signed [ACC_W-1:0]  w_out;

  assign kernel_loaded = r_loaded;
  assign win_ready     = r_loaded & ~kernel_load_valid;
  assign w_accept      = win_valid & win_ready;

  // Kernel storage; the first beat of a load invalidates the resident kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_kernel[i] <= '0;
      end
      r_kidx   <= '0;
      r_loaded <= 1'b0;
    end else if (kernel_load_valid) begin
      r_kernel[r_kidx] <= kernel_data;
      if (r_kidx == IDX_W'(TAPS - 1)) begin
        r_kidx   <= '0;
        r_loaded <= 1'b1;
      end else begin
        r_kidx <= r_kidx + IDX_W'(1);
        if (r_kidx == '0) begin
          r_loaded <= 1'b0;
        end
      end
    end
  end

  // Products are formed at acceptance, so a later reload cannot reach in-flight windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_first <= win_first;
      r_s1_last  <= win_last;
      if (w_accept) begin
        for (int i = 0; i < TAPS; i++) begin
          r_prod[i*P_W +: P_W] <= P_W'($signed(win_data[i*DATA_W +: DATA_W]) * r_kernel[i]);
        end
      end
    end
  end

  pe_adder_tree #(
    .N     (TAPS),
    .IN_W  (P_W),
    .OUT_W (ACC_W)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_s1_valid),
    .i_first (r_s1_first),
    .i_last  (r_s1_last),
    .i_data  (r_prod),
    .o_valid (w_s2_valid),
    .o_first (w_s2_first),
    .o_last  (w_s2_last),
    .o_sum   (w_sum)
  );

  // Accumulate step: a first channel restarts both the sum and the sticky flag.
  always_comb begin
    w_base     = r_acc;
    w_sat_base = r_sat;
    if (w_s2_first) begin
      w_base     = '0;
      w_sat_base = 1'b0;
    end else begin
      w_base     = r_acc;
      w_sat_base = r_sat;
    end
    w_add     = sat_add(64'(w_base), 64'(w_sum), ACC_W);
    w_res     = ACC_W'(w_add.val);
    w_sat_new = w_sat_base | w_add.ovf;
`ifdef PE_RELU_EN
    w_out = w_res[ACC_W-1] ? '0 : w_res;
`else
    w_out = w_res;
`endif
  end

  // Emitting a result zeroes the accumulator so a stray non-first window starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_sat     <= 1'b0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_sat   <= 1'b0;
    end else if (w_s2_valid) begin
      if (w_s2_last) begin
        r_acc     <= '0;
        r_sat     <= 1'b0;
        acc_valid <= 1'b1;
        acc_data  <= w_out;
        acc_sat   <= w_sat_new;
      end else begin
        r_acc     <= w_res;
        r_sat     <= w_sat_new;
        acc_valid <= 1'b0;
      end
    end else begin
      acc_valid <= 1'b0;
    end
  end

endmodule
